// File: rtl/gray_step_monitor_if.sv
// Bundle between the upstream Gray-code counter stage and its step monitor.
// valid is a sample strobe with no back-pressure: gray is examined in each cycle valid=1.
interface gray_step_monitor_if #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8
);
    logic [WIDTH-1:0]  gray;
    logic              valid;
    logic              clear;
    logic [WIDTH-1:0]  binary;
    logic              step;
    logic [WRAP_W-1:0] wraps;
    logic              error;
    logic [1:0]        dbg_state;

    modport master (
        output gray, valid, clear,
        input  binary, step, wraps, error, dbg_state
    );

    modport slave (
        input  gray, valid, clear,
        output binary, step, wraps, error, dbg_state
    );
endinterface

// File: rtl/gray_step_monitor.sv
// Samples a Gray code on valid, converts it to binary and flags anything other
// than a single forward step; counts max->0 wraps with saturation.
module gray_step_monitor #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8
) (
    input logic               i_clk,
    input logic               i_rst,
    gray_step_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_prev;
    logic [WIDTH-1:0]  r_binary;
    logic              r_step;
    logic [WRAP_W-1:0] r_wraps;
    logic              r_error;

    state_t            w_next_state;
    logic [WIDTH-1:0]  w_next_prev;
    logic [WIDTH-1:0]  w_next_binary;
    logic              w_next_step;
    logic [WRAP_W-1:0] w_next_wraps;
    logic              w_next_error;

    logic [WIDTH-1:0]  w_bin_gray;
    logic [WIDTH-1:0]  w_bin_prev;
    logic [WIDTH-1:0]  w_bin_next;
    logic [WIDTH-1:0]  w_diff;
    logic              w_same;
    logic              w_one_bit;
    logic              w_fwd;
    logic              w_wrap;

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_bin_gray = g2b(bus.gray);
    assign w_bin_prev = g2b(r_prev);
    assign w_bin_next = w_bin_prev + WIDTH'(1);
    assign w_diff     = bus.gray ^ r_prev;
    assign w_same     = (w_diff == '0);
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign w_one_bit  = !w_same && ((w_diff & (w_diff - WIDTH'(1))) == '0);
    assign w_fwd      = w_one_bit && (w_bin_gray == w_bin_next);
    assign w_wrap     = (w_bin_prev == '1) && (w_bin_gray == '0);

    always_comb begin
        w_next_state  = r_state;
        w_next_prev   = r_prev;
        w_next_binary = r_binary;
        w_next_step   = 1'b0;
        w_next_wraps  = r_wraps;
        w_next_error  = r_error;

        if (bus.clear) begin
            w_next_state  = S_INIT;
            w_next_prev   = '0;
            w_next_binary = '0;
            w_next_wraps  = '0;
            w_next_error  = 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (bus.valid) begin
                        w_next_prev   = bus.gray;
                        w_next_binary = w_bin_gray;
                        w_next_state  = S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (bus.valid && !w_same) begin
                        if (w_fwd) begin
                            w_next_prev   = bus.gray;
                            w_next_binary = w_bin_gray;
                            w_next_step   = 1'b1;
                            if (w_wrap && (r_wraps != '1)) begin
                                w_next_wraps = r_wraps + WRAP_W'(1);
                            end
                        end else begin
                            w_next_error = 1'b1;
                            w_next_state = S_FAULT;
                        end
                    end
                end
                S_FAULT: begin
                    w_next_error = 1'b1;
                end
                default: begin
                    w_next_state = S_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_INIT;
            r_prev   <= '0;
            r_binary <= '0;
            r_step   <= 1'b0;
            r_wraps  <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_prev   <= w_next_prev;
            r_binary <= w_next_binary;
            r_step   <= w_next_step;
            r_wraps  <= w_next_wraps;
            r_error  <= w_next_error;
        end
    end

    assign bus.binary    = r_binary;
    assign bus.step      = r_step;
    assign bus.wraps     = r_wraps;
    assign bus.error     = r_error;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed bench for gray_step_monitor: an 8-bit-wrap instance for the main
// sequences and a 2-bit-wrap instance for saturation.
module tb_gray_step_monitor;
    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic clk = 1'b0;
    logic rst8;
    logic rst2;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    gray_step_monitor_if #(.WIDTH(3), .WRAP_W(8)) if8 ();
    gray_step_monitor_if #(.WIDTH(3), .WRAP_W(2)) if2 ();

    gray_step_monitor #(.WIDTH(3), .WRAP_W(8)) dut8 (
        .i_clk (clk),
        .i_rst (rst8),
        .bus   (if8)
    );

    gray_step_monitor #(.WIDTH(3), .WRAP_W(2)) dut2 (
        .i_clk (clk),
        .i_rst (rst2),
        .bus   (if2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic drv8(input logic [2:0] g, input logic v, input logic c);
        if8.gray  = g;
        if8.valid = v;
        if8.clear = c;
    endtask

    task automatic drv2(input logic [2:0] g, input logic v, input logic c);
        if2.gray  = g;
        if2.valid = v;
        if2.clear = c;
    endtask

    task automatic exp8(input string tag, input logic [2:0] b, input logic s,
                        input logic [7:0] w, input logic e, input logic [1:0] st);
        check({tag, ".binary"}, 32'(if8.binary), 32'(b));
        check({tag, ".step"},   32'(if8.step),   32'(s));
        check({tag, ".wraps"},  32'(if8.wraps),  32'(w));
        check({tag, ".error"},  32'(if8.error),  32'(e));
        check({tag, ".state"},  32'(if8.dbg_state), 32'(st));
    endtask

    task automatic exp2(input string tag, input logic [2:0] b, input logic s,
                        input logic [1:0] w, input logic e, input logic [1:0] st);
        check({tag, ".binary"}, 32'(if2.binary), 32'(b));
        check({tag, ".step"},   32'(if2.step),   32'(s));
        check({tag, ".wraps"},  32'(if2.wraps),  32'(w));
        check({tag, ".error"},  32'(if2.error),  32'(e));
        check({tag, ".state"},  32'(if2.dbg_state), 32'(st));
    endtask

    initial begin
        logic [2:0] walk [0:8];
        logic [2:0] tail [0:6];
        logic [1:0] wexp;

        walk = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        tail = '{3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};

        // Reset
        rst8 = 1'b1;
        rst2 = 1'b1;
        drv8(3'b000, 1'b0, 1'b0);
        drv2(3'b000, 1'b0, 1'b0);
        tick();
        tick();
        exp8("reset8", 3'd0, 1'b0, 8'd0, 1'b0, ST_INIT);
        exp2("reset2", 3'd0, 1'b0, 2'd0, 1'b0, ST_INIT);
        rst8 = 1'b0;
        rst2 = 1'b0;

        // Full forward walk 0..7,0: first sample is reference only
        for (int i = 0; i < 9; i++) begin
            drv8(walk[i], 1'b1, 1'b0);
            tick();
            exp8($sformatf("walk%0d", i), (i == 8) ? 3'd0 : 3'(i), (i != 0),
                 (i == 8) ? 8'd1 : 8'd0, 1'b0, ST_TRACK);
        end
        drv8(3'b000, 1'b0, 1'b0);
        tick();
        exp8("idle", 3'd0, 1'b0, 8'd1, 1'b0, ST_TRACK);

        // Move to 011, then toggle gray while valid is low
        drv8(3'b001, 1'b1, 1'b0);
        tick();
        exp8("to1", 3'd1, 1'b1, 8'd1, 1'b0, ST_TRACK);
        drv8(3'b011, 1'b1, 1'b0);
        tick();
        exp8("to2", 3'd2, 1'b1, 8'd1, 1'b0, ST_TRACK);
        drv8(3'b110, 1'b0, 1'b0);
        tick();
        exp8("novalid_a", 3'd2, 1'b0, 8'd1, 1'b0, ST_TRACK);
        tick();
        exp8("novalid_b", 3'd2, 1'b0, 8'd1, 1'b0, ST_TRACK);
        drv8(3'b011, 1'b1, 1'b0);
        tick();
        exp8("same", 3'd2, 1'b0, 8'd1, 1'b0, ST_TRACK);

        // Backward single-bit step 011 -> 001
        drv8(3'b001, 1'b1, 1'b0);
        tick();
        exp8("back", 3'd2, 1'b0, 8'd1, 1'b1, ST_FAULT);
        drv8(3'b010, 1'b1, 1'b0);
        tick();
        exp8("fault_legal", 3'd2, 1'b0, 8'd1, 1'b1, ST_FAULT);

        // Clear together with valid: sample discarded
        drv8(3'b010, 1'b1, 1'b1);
        tick();
        exp8("clear1", 3'd0, 1'b0, 8'd0, 1'b0, ST_INIT);

        // Two-bit jump 000 -> 011
        drv8(3'b000, 1'b1, 1'b0);
        tick();
        exp8("ref0", 3'd0, 1'b0, 8'd0, 1'b0, ST_TRACK);
        drv8(3'b011, 1'b1, 1'b0);
        tick();
        exp8("jump", 3'd0, 1'b0, 8'd0, 1'b1, ST_FAULT);
        drv8(3'b001, 1'b1, 1'b0);
        tick();
        exp8("fault_step", 3'd0, 1'b0, 8'd0, 1'b1, ST_FAULT);
        drv8(3'b000, 1'b0, 1'b1);
        tick();
        exp8("clear2", 3'd0, 1'b0, 8'd0, 1'b0, ST_INIT);
        drv8(3'b001, 1'b1, 1'b0);
        tick();
        exp8("ref1", 3'd1, 1'b0, 8'd0, 1'b0, ST_TRACK);

        // Walk onward through a wrap, then reset between edges
        drv8(3'b011, 1'b1, 1'b0);
        tick();
        exp8("pre2", 3'd2, 1'b1, 8'd0, 1'b0, ST_TRACK);
        for (int i = 0; i < 7; i++) begin
            drv8(tail[i], 1'b1, 1'b0);
            tick();
            exp8($sformatf("tail%0d", i), 3'((3 + i) % 8), 1'b1,
                 (i >= 5) ? 8'd1 : 8'd0, 1'b0, ST_TRACK);
        end
        drv8(3'b000, 1'b0, 1'b0);
        #2;
        rst8 = 1'b1;
        #1;
        exp8("async_rst", 3'd0, 1'b0, 8'd0, 1'b0, ST_INIT);
        #1;
        rst8 = 1'b0;
        drv8(3'b011, 1'b1, 1'b0);
        tick();
        exp8("post_rst_ref", 3'd2, 1'b0, 8'd0, 1'b0, ST_TRACK);
        drv8(3'b010, 1'b1, 1'b0);
        tick();
        exp8("post_rst_step", 3'd3, 1'b1, 8'd0, 1'b0, ST_TRACK);
        drv8(3'b000, 1'b0, 1'b0);

        // Saturating wrap counter on the 2-bit instance
        drv2(3'b000, 1'b1, 1'b0);
        tick();
        exp2("w2_ref", 3'd0, 1'b0, 2'd0, 1'b0, ST_TRACK);
        for (int c = 0; c < 5; c++) begin
            for (int k = 1; k < 9; k++) begin
                drv2(walk[k], 1'b1, 1'b0);
                tick();
                check($sformatf("w2_c%0d_k%0d.binary", c, k), 32'(if2.binary), 32'(k % 8));
                check($sformatf("w2_c%0d_k%0d.step", c, k), 32'(if2.step), 32'd1);
                if (k == 8) begin
                    wexp = (c < 3) ? 2'(c + 1) : 2'd3;
                    check($sformatf("w2_c%0d.wraps", c), 32'(if2.wraps), 32'(wexp));
                end
            end
        end
        drv2(3'b001, 1'b1, 1'b1);
        tick();
        exp2("w2_clear", 3'd0, 1'b0, 2'd0, 1'b0, ST_INIT);
        drv2(3'b011, 1'b1, 1'b0);
        tick();
        exp2("w2_ref2", 3'd2, 1'b0, 2'd0, 1'b0, ST_TRACK);
        drv2(3'b000, 1'b0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
